// File: rtl/mem_access_stage.sv
// MEM-stage controller: runs LD/ST against a variable-latency data memory and owns the MEM/WB register.
// Optional WAIT-state timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exmem_valid,
  input  logic        exmem_memread,
  input  logic        exmem_memwrite,
  input  logic [15:0] exmem_addr,
  input  logic [15:0] exmem_wdata,
  input  logic [15:0] exmem_instr,
  input  logic        exmem_regwe,
  input  logic [1:0]  exmem_wrsel,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_stall,
  input  logic        mem_done,
  input  logic [15:0] mem_rdata,
  input  logic        mem_err,
  output logic        stall_pipe,
  output logic        memwb_valid,
  output logic        memwb_regwe,
  output logic        memwb_memread,
  output logic        memwb_err,
  output logic [1:0]  memwb_wrsel,
  output logic [15:0] memwb_instr,
  output logic [15:0] memwb_alu,
  output logic [15:0] memwb_rdata,
  output logic        err_sticky
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t state_reg, state_next;

  logic        memop;
  logic        timeout;
  logic        lat_wr_reg;
  logic        lat_memread_reg;
  logic        lat_regwe_reg;
  logic        lat_err_reg;
  logic [1:0]  lat_wrsel_reg;
  logic [15:0] lat_addr_reg;
  logic [15:0] lat_wdata_reg;
  logic [15:0] lat_instr_reg;
  logic [15:0] lat_rdata_reg;

  assign memop = exmem_valid & (exmem_memread | exmem_memwrite);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_reg;

  // Counter is cleared while in ISSUE so every WAIT entry starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == ISSUE) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == WAIT) begin
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end

  assign timeout = (state_reg == WAIT) && !mem_done &&
                   (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    mem_req    = 1'b0;
    stall_pipe = 1'b0;
    case (state_reg)
      IDLE: begin
        if (memop) begin
          stall_pipe = 1'b1;
          state_next = exmem_addr[0] ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        mem_req    = 1'b1;
        stall_pipe = 1'b1;
        if (!mem_stall) state_next = WAIT;
      end
      WAIT: begin
        stall_pipe = 1'b1;
        if (mem_done || timeout) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Outputs must read 0 throughout reset, even with a memop presented upstream.
    if (!rst_n) begin
      mem_req    = 1'b0;
      stall_pipe = 1'b0;
    end
  end

  assign mem_wr    = mem_req & lat_wr_reg;
  assign mem_addr  = lat_addr_reg;
  assign mem_wdata = lat_wdata_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_wr_reg      <= 1'b0;
      lat_memread_reg <= 1'b0;
      lat_regwe_reg   <= 1'b0;
      lat_err_reg     <= 1'b0;
      lat_wrsel_reg   <= '0;
      lat_addr_reg    <= '0;
      lat_wdata_reg   <= '0;
      lat_instr_reg   <= '0;
      lat_rdata_reg   <= '0;
      memwb_valid     <= 1'b0;
      memwb_regwe     <= 1'b0;
      memwb_memread   <= 1'b0;
      memwb_err       <= 1'b0;
      memwb_wrsel     <= '0;
      memwb_instr     <= '0;
      memwb_alu       <= '0;
      memwb_rdata     <= '0;
      err_sticky      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (memop) begin
            lat_wr_reg      <= exmem_memwrite;
            lat_memread_reg <= exmem_memread & ~exmem_memwrite;
            lat_regwe_reg   <= exmem_regwe;
            lat_err_reg     <= exmem_addr[0];
            lat_wrsel_reg   <= exmem_wrsel;
            lat_addr_reg    <= exmem_addr;
            lat_wdata_reg   <= exmem_wdata;
            lat_instr_reg   <= exmem_instr;
            lat_rdata_reg   <= '0;
          end
        end
        WAIT: begin
          if (mem_done) begin
            lat_err_reg   <= mem_err;
            lat_rdata_reg <= (lat_memread_reg && !mem_err) ? mem_rdata : 16'h0000;
          end else if (timeout) begin
            lat_err_reg   <= 1'b1;
            lat_rdata_reg <= '0;
          end
        end
        default: ;
      endcase

      if (state_reg == RESP) begin
        memwb_valid   <= 1'b1;
        memwb_regwe   <= lat_regwe_reg & ~lat_err_reg;
        memwb_memread <= lat_memread_reg;
        memwb_err     <= lat_err_reg;
        memwb_wrsel   <= lat_wrsel_reg;
        memwb_instr   <= lat_instr_reg;
        memwb_alu     <= lat_addr_reg;
        memwb_rdata   <= lat_rdata_reg;
        err_sticky    <= err_sticky | lat_err_reg;
      end else if (stall_pipe) begin
        // Bubble: kill enables so forwarding never sees stale write-back; data held.
        memwb_valid   <= 1'b0;
        memwb_regwe   <= 1'b0;
        memwb_memread <= 1'b0;
        memwb_err     <= 1'b0;
      end else begin
        memwb_valid   <= exmem_valid;
        memwb_regwe   <= exmem_valid & exmem_regwe;
        memwb_memread <= 1'b0;
        memwb_err     <= 1'b0;
        memwb_wrsel   <= exmem_wrsel;
        memwb_instr   <= exmem_instr;
        memwb_alu     <= exmem_addr;
        memwb_rdata   <= '0;
      end
    end
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage controller that sits directly downstream of the M-stage forwarding unit and owns the MEM/WB pipeline register.
- Consumes the EX/MEM instruction, address and forwarded store data (RegData2 after forwarding), and runs LD/ST against a variable-latency data memory with a req/stall/done handshake.
- Freezes the upstream pipeline while an access is outstanding.
- Produces the MEM/WB fields (including MemReadRst) that the forwarding and write-back logic read.

Parameters:
- TIMEOUT_CYCLES, 64, WAIT-state cycle limit before a forced error; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- exmem_valid  in  1  EX/MEM holds a real instruction
- exmem_memread  in  1  instruction is a LD
- exmem_memwrite  in  1  instruction is a ST
- exmem_addr  in  16  ALU result / memory address
- exmem_wdata  in  16  store data after M-stage forwarding
- exmem_instr  in  16  instruction word
- exmem_regwe  in  1  register write enable
- exmem_wrsel  in  2  write-register select
- mem_req  out  1  memory request
- mem_wr  out  1  1 = write, 0 = read
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_stall  in  1  memory busy; request not accepted this cycle
- mem_done  in  1  access complete
- mem_rdata  in  16  read data, valid with mem_done
- mem_err  in  1  access fault, valid with mem_done
- stall_pipe  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- memwb_valid, memwb_regwe, memwb_memread, memwb_err  out  1 each  MEM/WB fields
- memwb_wrsel  out  2
- memwb_instr, memwb_alu, memwb_rdata  out  16 each
- err_sticky  out  1  set by any faulted access; cleared only by reset

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, FSM to IDLE, timeout counter 0. mem_req drops in the same cycle even mid-access; a mem_done arriving after reset is ignored.
- memop = exmem_valid & (exmem_memread | exmem_memwrite). If both read and write are set, the access is treated as a ST.
- IDLE:
  - Non-memop: the MEM/WB register loads the EX/MEM fields every cycle, memwb_rdata = 0, 1-cycle latency, stall_pipe = 0.
  - memop: latch addr, wdata, instruction and control fields; stall_pipe = 1.
  - memop with exmem_addr[0] = 1 (misaligned): go to RESP with err = 1; no memory request is issued.
  - memop otherwise: go to ISSUE.
- ISSUE:
  - mem_req = 1; mem_wr, mem_addr and mem_wdata come from latched values and are held stable until accepted.
  - mem_stall = 1: stay in ISSUE. mem_stall = 0: go to WAIT.
  - mem_done is ignored in ISSUE.
- WAIT:
  - mem_req = 0.
  - On mem_done: capture mem_rdata for a LD, or 0 for a ST; capture err = mem_err, and force rdata to 0 when err = 1. Go to RESP.
- RESP:
  - The MEM/WB register loads the latched fields.
  - memwb_regwe is forced to 0 when err = 1.
  - err_sticky is set if err = 1.
  - stall_pipe = 0, so EX/MEM advances this cycle. Go to IDLE.
- stall_pipe = 1 in ISSUE, WAIT, and IDLE-with-memop; 0 otherwise.
- While stall_pipe = 1, MEM/WB loads a bubble: all valid/enable fields 0, data held. This keeps downstream forwarding from seeing stale write-back.
- Minimum aligned-memop latency: IDLE, ISSUE, WAIT (done 1 cycle after acceptance), RESP = 4 cycles from EX/MEM entry to MEM/WB valid.
- Back-to-back memops: RESP to IDLE, and the next memop is detected the following cycle.
- exmem_valid = 0: bubble propagates; no memory access.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined: a counter resets on entry to WAIT and increments each WAIT cycle. If it reaches TIMEOUT_CYCLES without mem_done, force err = 1 and rdata = 0, and go to RESP. A later stray mem_done in IDLE is ignored.
- Undefined: no counter; WAIT holds indefinitely until mem_done.

Test Plan:
- Reset: rst_n = 0 during WAIT -> mem_req, stall_pipe and every memwb_* output are 0 in the same cycle; the FSM restarts in IDLE.
- Non-mem ADD, regwe = 1, alu = 0x1234 -> next cycle memwb_valid = 1, memwb_alu = 0x1234, memwb_rdata = 0, stall_pipe never asserted.
- LD addr 0x0040, mem_stall high 2 cycles, done 3 cycles after accept with rdata 0xBEEF -> mem_req held 3 cycles with addr 0x0040 stable; stall_pipe high throughout; MEM/WB bubbles during stall; then memwb_rdata = 0xBEEF, memwb_memread = 1, stall_pipe low in RESP.
- ST addr 0x0010, wdata 0xA5A5 -> mem_wr = 1, mem_wdata = 0xA5A5; memwb_rdata = 0; LD to 0x0010 immediately after issues only after the ST's RESP.
- Misaligned LD addr 0x0031 -> no mem_req; memwb_err = 1, memwb_regwe = 0, err_sticky = 1 after 2 cycles.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES = 4, mem_done never asserted -> after 4 WAIT cycles memwb_err = 1 and err_sticky = 1; without the macro, stall_pipe stays high for 100 cycles.
